// File: rtl/eth_phy_rx_block_sync_if.sv
// Sync-header input and lock/BER status bundle between the SerDes receive path and the
// block-sync core. The core connects through the slave modport.
interface eth_phy_rx_block_sync_if #(
    parameter int HDR_WIDTH     = 2,
    parameter int ERR_CNT_WIDTH = 16
);
    logic [HDR_WIDTH-1:0]     serdes_rx_hdr;
    logic                     serdes_rx_hdr_valid;
    logic                     rx_error_count_clr;
    logic                     serdes_rx_bitslip;
    logic                     serdes_rx_reset_req;
    logic                     rx_block_lock;
    logic                     rx_high_ber;
    logic                     rx_status;
    logic [ERR_CNT_WIDTH-1:0] rx_error_count;

    modport master (
        output serdes_rx_hdr, serdes_rx_hdr_valid, rx_error_count_clr,
        input  serdes_rx_bitslip, serdes_rx_reset_req, rx_block_lock,
               rx_high_ber, rx_status, rx_error_count
    );

    modport slave (
        input  serdes_rx_hdr, serdes_rx_hdr_valid, rx_error_count_clr,
        output serdes_rx_bitslip, serdes_rx_reset_req, rx_block_lock,
               rx_high_ber, rx_status, rx_error_count
    );
endinterface

// File: rtl/eth_phy_rx_block_sync.sv
// 64b/66b receive block synchroniser: hunts for sync-header lock with bitslip, monitors
// bit-error rate per 125 us window, and requests a SerDes reset after a long unlocked spell.
module eth_phy_rx_block_sync #(
    parameter int HDR_WIDTH           = 2,
    parameter int LOCK_COUNT          = 64,
    parameter int UNLOCK_ERR          = 16,
    parameter int BITSLIP_HIGH_CYCLES = 1,
    parameter int BITSLIP_LOW_CYCLES  = 8,
    parameter int COUNT_125US         = 19531,
    parameter int BER_THRESH          = 16,
    parameter int RESET_TIMEOUT       = 4096,
    parameter int ERR_CNT_WIDTH       = 16
) (
    input logic                    clk,
    input logic                    rst,
    eth_phy_rx_block_sync_if.slave bus
);
    localparam int HDR_CNT_W = $clog2(LOCK_COUNT + 1);
    localparam int ERR_W     = $clog2(UNLOCK_ERR + 1);
    localparam int PHASE_MAX = (BITSLIP_HIGH_CYCLES > BITSLIP_LOW_CYCLES) ?
                               BITSLIP_HIGH_CYCLES : BITSLIP_LOW_CYCLES;
    localparam int PHASE_W   = $clog2(PHASE_MAX + 1);
    localparam int BER_T_W   = $clog2(COUNT_125US + 1);
    localparam int BER_C_W   = $clog2(BER_THRESH + 1);
    localparam int UNL_W     = $clog2(RESET_TIMEOUT + 1);

    typedef enum logic [1:0] {UNLOCKED, SLIP, SETTLE, LOCKED} state_t;

    state_t                   state, state_next;
    logic [HDR_CNT_W-1:0]     hdr_cnt, hdr_cnt_next;
    logic [ERR_W-1:0]         err_cnt, err_cnt_next;
    logic [PHASE_W-1:0]       phase_cnt, phase_next;
    logic                     bitslip_q, lock_q;
    logic [BER_T_W-1:0]       ber_timer;
    logic [BER_C_W-1:0]       ber_cnt;
    logic                     high_ber_q, status_q;
    logic [UNL_W-1:0]         unl_timer;
    logic                     reset_req_q;
    logic [ERR_CNT_WIDTH-1:0] err_total;

    logic hdr_match, hdr_ok, hdr_bad, lock_err, ber_wrap;

    assign hdr_match = (bus.serdes_rx_hdr == HDR_WIDTH'(1)) || (bus.serdes_rx_hdr == HDR_WIDTH'(2));
    assign hdr_ok    = bus.serdes_rx_hdr_valid && hdr_match;
    assign hdr_bad   = bus.serdes_rx_hdr_valid && !hdr_match;
    assign lock_err  = lock_q && hdr_bad;
    assign ber_wrap  = (ber_timer == BER_T_W'(COUNT_125US - 1));

    // hdr_cnt counts consecutive good headers while hunting and window headers while locked.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        state_next   = state;
        hdr_cnt_next = hdr_cnt;
        err_cnt_next = err_cnt;
        phase_next   = phase_cnt;
        unique case (state)
            UNLOCKED: begin
                if (hdr_ok) begin
                    if (hdr_cnt == HDR_CNT_W'(LOCK_COUNT - 1)) begin
                        state_next   = LOCKED;
                        hdr_cnt_next = '0;
                        err_cnt_next = '0;
                    end else begin
                        hdr_cnt_next = hdr_cnt + HDR_CNT_W'(1);
                    end
                end else if (hdr_bad) begin
                    state_next   = SLIP;
                    hdr_cnt_next = '0;
                    phase_next   = '0;
                end
            end
            SLIP: begin
                if (phase_cnt == PHASE_W'(BITSLIP_HIGH_CYCLES - 1)) begin
                    state_next = SETTLE;
                    phase_next = '0;
                end else begin
                    phase_next = phase_cnt + PHASE_W'(1);
                end
            end
            SETTLE: begin
                if (phase_cnt == PHASE_W'(BITSLIP_LOW_CYCLES - 1)) begin
                    state_next   = UNLOCKED;
                    phase_next   = '0;
                    hdr_cnt_next = '0;
                    err_cnt_next = '0;
                end else begin
                    phase_next = phase_cnt + PHASE_W'(1);
                end
            end
            LOCKED: begin
                if (bus.serdes_rx_hdr_valid) begin
                    // The lock-dropping error wins even when it is also the window's last header.
                    if (hdr_bad && err_cnt == ERR_W'(UNLOCK_ERR - 1)) begin
                        state_next   = SLIP;
                        hdr_cnt_next = '0;
                        err_cnt_next = '0;
                        phase_next   = '0;
                    end else if (hdr_cnt == HDR_CNT_W'(LOCK_COUNT - 1)) begin
                        hdr_cnt_next = '0;
                        err_cnt_next = '0;
                    end else begin
                        hdr_cnt_next = hdr_cnt + HDR_CNT_W'(1);
                        err_cnt_next = err_cnt + ERR_W'(hdr_bad);
                    end
                end
            end
            default: state_next = UNLOCKED;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= UNLOCKED;
            hdr_cnt   <= '0;
            err_cnt   <= '0;
            phase_cnt <= '0;
            bitslip_q <= 1'b0;
            lock_q    <= 1'b0;
        end else begin
            // NOTE: registers use <= so every one samples the same pre-edge values.
            state     <= state_next;
            hdr_cnt   <= hdr_cnt_next;
            err_cnt   <= err_cnt_next;
            phase_cnt <= phase_next;
            bitslip_q <= (state_next == SLIP);
            lock_q    <= (state_next == LOCKED);
        end
    end

    // BER monitor: a coincident error at the wrap opens the new window with a count of one.
    always_ff @(posedge clk) begin
        if (rst) begin
            ber_timer  <= '0;
            ber_cnt    <= '0;
            high_ber_q <= 1'b0;
            status_q   <= 1'b0;
        end else begin
            status_q <= lock_q && !high_ber_q;
            if (ber_wrap) begin
                ber_timer  <= '0;
                ber_cnt    <= BER_C_W'(lock_err);
                high_ber_q <= (ber_cnt == BER_C_W'(BER_THRESH)) || (lock_err && BER_THRESH == 1);
            end else begin
                ber_timer <= ber_timer + BER_T_W'(1);
                if (lock_err && ber_cnt != BER_C_W'(BER_THRESH)) begin
                    ber_cnt <= ber_cnt + BER_C_W'(1);
                    if (ber_cnt == BER_C_W'(BER_THRESH - 1)) high_ber_q <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            unl_timer   <= '0;
            reset_req_q <= 1'b0;
            err_total   <= '0;
        end else begin
            if (lock_q) begin
                unl_timer   <= '0;
                reset_req_q <= 1'b0;
            end else if (unl_timer == UNL_W'(RESET_TIMEOUT - 1)) begin
                unl_timer   <= '0;
                reset_req_q <= 1'b1;
            end else begin
                unl_timer   <= unl_timer + UNL_W'(1);
                reset_req_q <= 1'b0;
            end

            if (bus.rx_error_count_clr) begin
                err_total <= ERR_CNT_WIDTH'(lock_err);
            end else if (lock_err && err_total != '1) begin
                err_total <= err_total + ERR_CNT_WIDTH'(1);
            end
        end
    end

    assign bus.serdes_rx_bitslip   = bitslip_q;
    assign bus.serdes_rx_reset_req = reset_req_q;
    assign bus.rx_block_lock       = lock_q;
    assign bus.rx_high_ber         = high_ber_q;
    assign bus.rx_status           = status_q;
    assign bus.rx_error_count      = err_total;
endmodule
